// File: rtl/step_settle_monitor.sv
`default_nettype none
// ============================================================================
// Module      : step_settle_monitor
// Description : Measures settling time, peak and overshoot of a step response.
// Revision    : 1.0 - initial release
// ============================================================================
module step_settle_monitor #(
   parameter int WIDTH       = 25,
   parameter int CNT_W       = 16,
   parameter int HOLD_CYCLES = 16,
   parameter int TIMEOUT     = 4096
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic signed [WIDTH-1:0] sample,
   input  logic signed [WIDTH-1:0] target,
   input  logic [WIDTH-2:0]        tol,
   output logic                    busy,
   output logic                    done,
   output logic                    settled,
   output logic                    timeout,
   output logic [CNT_W-1:0]        settle_time,
   output logic signed [WIDTH-1:0] peak,
   output logic [WIDTH-2:0]        overshoot
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_TRACK = 2'd1,
      S_HOLD  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] c_hold = CNT_W'(HOLD_CYCLES);
   localparam logic [CNT_W-1:0] c_last = CNT_W'(TIMEOUT - 1);

   state_t                  r_state;
   state_t                  w_next;
   logic signed [WIDTH-1:0] r_target;
   logic [WIDTH-2:0]        r_tol;
   logic [CNT_W-1:0]        r_elapsed;
   logic [CNT_W-1:0]        r_hold_cnt;
   logic [CNT_W-1:0]        r_cand;
   logic signed [WIDTH-1:0] r_peak_run;

   logic                    w_eval;
   logic [WIDTH:0]          w_diff;
   logic [WIDTH:0]          w_err;
   logic                    w_in_tol;
   logic signed [WIDTH-1:0] w_peak_new;
   logic [WIDTH:0]          w_ovs_diff;
   logic [WIDTH-2:0]        w_ovs;
   logic [CNT_W-1:0]        w_hold_inc;
   logic [CNT_W-1:0]        w_cand;
   logic                    w_settle;
   logic                    w_finish;

   // Differences are taken one bit wider than the operands so they never wrap.
   assign w_eval     = (r_state == S_TRACK) || (r_state == S_HOLD);
   assign w_diff     = {sample[WIDTH-1], sample} - {r_target[WIDTH-1], r_target};
   assign w_err      = w_diff[WIDTH] ? (~w_diff + 1'b1) : w_diff;
   assign w_in_tol   = (w_err <= {2'b00, r_tol});
   assign w_peak_new = ((r_elapsed == '0) || (sample > r_peak_run)) ? sample : r_peak_run;
   assign w_ovs_diff = {w_peak_new[WIDTH-1], w_peak_new} - {r_target[WIDTH-1], r_target};
   assign w_ovs      = w_ovs_diff[WIDTH]   ? '0 :
                       w_ovs_diff[WIDTH-1] ? '1 : w_ovs_diff[WIDTH-2:0];
   assign w_hold_inc = r_hold_cnt + 1'b1;
   assign w_cand     = (r_state == S_TRACK) ? r_elapsed : r_cand;
   assign w_settle   = w_in_tol &&
                       (((r_state == S_TRACK) && (HOLD_CYCLES == 1)) ||
                        ((r_state == S_HOLD) && (w_hold_inc == c_hold)));
   assign w_finish   = w_eval && (w_settle || (r_elapsed == c_last));

   assign busy = w_eval;
   assign done = (r_state == S_DONE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_next = S_TRACK;
         S_TRACK: begin
            if (w_finish)      w_next = S_DONE;
            else if (w_in_tol) w_next = S_HOLD;
         end
         S_HOLD: begin
            if (w_finish)       w_next = S_DONE;
            else if (!w_in_tol) w_next = S_TRACK;
         end
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_target    <= '0;
         r_tol       <= '0;
         r_elapsed   <= '0;
         r_hold_cnt  <= '0;
         r_cand      <= '0;
         r_peak_run  <= '0;
         settled     <= 1'b0;
         timeout     <= 1'b0;
         settle_time <= '0;
         peak        <= '0;
         overshoot   <= '0;
      end else begin
         if ((r_state == S_IDLE) && start) begin
            r_target   <= target;
            r_tol      <= tol;
            r_elapsed  <= '0;
            r_hold_cnt <= '0;
         end
         if (w_eval) begin
            r_elapsed  <= r_elapsed + 1'b1;
            r_peak_run <= w_peak_new;
            if (r_state == S_TRACK) begin
               if (w_in_tol) begin
                  r_hold_cnt <= CNT_W'(1);
                  r_cand     <= r_elapsed;
               end
            end else begin
               r_hold_cnt <= w_in_tol ? w_hold_inc : '0;
            end
            // A settle on the final allowed cycle takes precedence over timeout.
            if (w_finish) begin
               settled     <= w_settle;
               timeout     <= !w_settle;
               settle_time <= w_settle ? w_cand : '1;
               peak        <= w_peak_new;
               overshoot   <= w_ovs;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_step_settle_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_step_settle_monitor
// Description : Directed and randomized bench for step_settle_monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_step_settle_monitor;

   localparam int c_to = 64;

   logic               clk = 1'b0;
   logic               rst = 1'b0;
   logic               start = 1'b0;
   logic               sel = 1'b0;
   logic signed [24:0] sample = '0;
   logic signed [24:0] target = '0;
   logic [23:0]        tol = '0;

   logic               busy_a, done_a, settled_a, timeout_a;
   logic               busy_b, done_b, settled_b, timeout_b;
   logic [15:0]        st_a, st_b;
   logic signed [24:0] peak_a, peak_b;
   logic [23:0]        ovs_a, ovs_b;
   logic               w_start_a, w_start_b;

   logic               w_busy, w_done, w_settled, w_timeout;
   logic [15:0]        w_st;
   logic signed [24:0] w_peak;
   logic [23:0]        w_ovs;

   longint stim [c_to];
   longint exp_hold_pk [2];
   int     n_chk = 0;
   int     n_err = 0;

   always #5 clk = ~clk;

   assign w_start_a = start & ~sel;
   assign w_start_b = start & sel;
   assign w_busy    = sel ? busy_b    : busy_a;
   assign w_done    = sel ? done_b    : done_a;
   assign w_settled = sel ? settled_b : settled_a;
   assign w_timeout = sel ? timeout_b : timeout_a;
   assign w_st      = sel ? st_b      : st_a;
   assign w_peak    = sel ? peak_b    : peak_a;
   assign w_ovs     = sel ? ovs_b     : ovs_a;

   step_settle_monitor #(.WIDTH(25), .CNT_W(16), .HOLD_CYCLES(16), .TIMEOUT(c_to)) u_dut_a (
      .clk(clk), .rst(rst), .start(w_start_a), .sample(sample), .target(target), .tol(tol),
      .busy(busy_a), .done(done_a), .settled(settled_a), .timeout(timeout_a),
      .settle_time(st_a), .peak(peak_a), .overshoot(ovs_a));

   step_settle_monitor #(.WIDTH(25), .CNT_W(16), .HOLD_CYCLES(1), .TIMEOUT(c_to)) u_dut_b (
      .clk(clk), .rst(rst), .start(w_start_b), .sample(sample), .target(target), .tol(tol),
      .busy(busy_b), .done(done_b), .settled(settled_b), .timeout(timeout_b),
      .settle_time(st_b), .peak(peak_b), .overshoot(ovs_b));

   task automatic check(input string tag, input longint got, input longint exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reference: scan the stimulus for the first run of hold in-tolerance samples.
   function automatic void model(input int hold, input longint tgt, input longint tl,
                                 output int f, output bit ok, output longint st,
                                 output longint pk, output longint ov);
      int run = 0;
      ok = 0; st = 65535; f = c_to - 1; pk = 0;
      for (int k = 0; k < c_to; k++) begin
         longint e = stim[k] - tgt;
         if (e < 0) e = -e;
         if (k == 0 || stim[k] > pk) pk = stim[k];
         run = (e <= tl) ? run + 1 : 0;
         if (run == hold) begin
            ok = 1; st = k - hold + 1; f = k;
            break;
         end
      end
      ov = pk - tgt;
      if (ov < 0) ov = 0;
      if (ov > 64'sd16777215) ov = 64'sd16777215;
   endfunction

   task automatic run_meas(input bit s, input longint tgt, input longint tl, input bit noisy);
      int     f;
      bit     ok;
      bit     got;
      longint est, epk, eov;
      model(s ? 1 : 16, tgt, tl, f, ok, est, epk, eov);
      @(negedge clk);
      sel = s; start = 1'b1; target = 25'(tgt); tol = 24'(tl); sample = 25'($urandom);
      @(negedge clk);
      start = 1'b0; sample = 25'(stim[0]);
      if (noisy) begin
         target = 25'($urandom); tol = 24'($urandom);
      end
      got = 0;
      for (int j = 1; j <= c_to + 6 && !got; j++) begin
         @(negedge clk);
         check("done", w_done, longint'(j - 1 == f));
         if (w_done) begin
            got = 1;
            check("settled", w_settled, ok);
            check("timeout", w_timeout, !ok);
            check("settle_time", w_st, est);
            check("peak", w_peak, epk);
            check("overshoot", w_ovs, eov);
            exp_hold_pk[s] = epk;
         end else begin
            check("busy", w_busy, 1);
            check("peak_hold", w_peak, exp_hold_pk[s]);
            sample = (j < c_to) ? 25'(stim[j]) : '0;
            start  = noisy && ($urandom_range(0, 7) == 0);
         end
      end
      if (!got) check("done_seen", 0, 1);
      start = noisy;
      @(negedge clk);
      start = 1'b0;
      check("idle_busy", w_busy, 0);
      check("idle_done", w_done, 0);
   endtask

   task automatic fill_random(input longint tgt, input longint tl);
      int p = $urandom_range(80, 100);
      for (int k = 0; k < c_to; k++) begin
         if ($urandom_range(1, 100) <= p) begin
            stim[k] = tgt + longint'($urandom_range(0, 2 * tl)) - tl;
         end else begin
            longint m = tl + 1 + longint'($urandom_range(0, 300));
            stim[k] = ($urandom_range(0, 1) == 1) ? tgt + m : tgt - m;
         end
      end
   endtask

   initial begin
      exp_hold_pk[0] = 0;
      exp_hold_pk[1] = 0;
      repeat (3) @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         sel = s[0];
         #1;
         check("rst_busy", w_busy, 0);
         check("rst_done", w_done, 0);
         check("rst_st", w_st, 0);
         check("rst_peak", w_peak, 0);
      end
      rst = 1'b1;

      // Constant in tolerance
      for (int k = 0; k < c_to; k++) stim[k] = 1000;
      run_meas(0, 1000, 10, 0);
      check("const_st", st_a, 0);
      check("const_peak", peak_a, 1000);

      // Reset mid-measurement abandons it
      for (int k = 0; k < c_to; k++) stim[k] = 0;
      @(negedge clk);
      sel = 1'b0; start = 1'b1; target = 25'sd1000; tol = 24'd10; sample = '0;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      check("pre_rst_busy", busy_a, 1);
      #2 rst = 1'b0;
      #1;
      check("arst_busy", busy_a, 0);
      check("arst_settled", settled_a, 0);
      check("arst_st", st_a, 0);
      check("arst_peak", peak_a, 0);
      check("arst_timeout", timeout_a, 0);
      check("arst_ovs", ovs_a, 0);
      exp_hold_pk[0] = 0;
      repeat (3) begin
         @(negedge clk);
         check("arst_done", done_a, 0);
      end
      rst = 1'b1;

      // Overshoot then settle
      for (int k = 0; k < c_to; k++) stim[k] = (k < 5) ? 0 : (k < 8) ? 1100 : 1000;
      run_meas(0, 1000, 10, 0);
      check("ovs_st", st_a, 8);
      check("ovs_val", ovs_a, 100);
      check("ovs_timeout", timeout_a, 0);

      // Glitch during hold
      for (int k = 0; k < c_to; k++) stim[k] = (k < 2) ? 0 : (k == 10) ? 1050 : 1000;
      run_meas(0, 1000, 10, 1);
      check("glitch_st", st_a, 11);

      // Never settles
      for (int k = 0; k < c_to; k++) stim[k] = 0;
      run_meas(0, 1000, 10, 1);
      check("to_flag", timeout_a, 1);
      check("to_st", st_a, 16'hFFFF);
      check("to_peak", peak_a, 0);

      // Single-cycle hold, first sample in tolerance
      for (int k = 0; k < c_to; k++) stim[k] = 500;
      run_meas(1, 505, 5, 0);
      check("h1_settled", settled_b, 1);
      check("h1_st", st_b, 0);

      // Extreme operands: error must not wrap, overshoot saturates
      for (int k = 0; k < c_to; k++) stim[k] = 16777215;
      run_meas(1, -16777216, 5, 0);
      check("ext_timeout", timeout_b, 1);
      check("ext_ovs", ovs_b, 24'hFFFFFF);

      for (int r = 0; r < 24; r++) begin
         longint tgt = longint'($urandom_range(0, 2000000)) - 1000000;
         longint tl  = longint'($urandom_range(0, 40));
         fill_random(tgt, tl);
         run_meas($urandom_range(0, 1) == 1, tgt, tl, 1);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
